adder_acc: RTL and testbench

ADDER_ACC -- requirements
Module: adder_acc

---
 rtl/adder_acc.sv | 98 +++++++++
 tb/tb_adder_acc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_acc.sv
// Collects a counted run of upstream adder results into a running total
// and overflow count, then holds the result until the consumer acknowledges.
module adder_acc (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Clear,
  input  logic       Start,
  input  logic [3:0] Count,
  input  logic       In_valid,
  input  logic [3:0] Sum,
  input  logic       Overflow,
  input  logic       Ack,
  output logic [8:0] Total,
  output logic [4:0] Ovf_cnt,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [8:0] total_q;
  logic [4:0] ovf_q;
  logic [4:0] remaining;
  logic       load;
  logic       take;
  logic [4:0] run_len;
  logic [8:0] sample;

  // Count of zero encodes a full run of sixteen samples.
  always_comb begin
    load    = (state == IDLE) && Start;
    take    = (state == ACCUM) && In_valid;
    run_len = (Count == 4'd0) ? 5'd16 : {1'b0, Count};
    sample  = {4'b0000, Overflow, Sum};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (Start) state_nx = ACCUM;
      end
      ACCUM: begin
        if (In_valid && remaining == 5'd1)
          state_nx = DONE;
      end
      DONE: begin
        if (Ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (Clear) state_nx = IDLE;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      total_q   <= '0;
      ovf_q     <= '0;
      remaining <= '0;
    end else if (Clear) begin
      total_q   <= '0;
      ovf_q     <= '0;
      remaining <= '0;
    end else if (load) begin
      total_q   <= '0;
      ovf_q     <= '0;
      remaining <= run_len;
    end else if (take) begin
      total_q   <= total_q + sample;
      ovf_q     <= ovf_q + {4'b0000, Overflow};
      remaining <= remaining - 5'd1;
    end
  end

  // Status flags come straight from the state register.
  always_comb begin
    Busy = (state == ACCUM);
    Done = (state == DONE);
  end

  assign Total   = total_q;
  assign Ovf_cnt = ovf_q;

endmodule

// File: tb/tb_adder_acc.sv
// Directed bench for adder_acc: a scoreboard queue of expected run
// results, checked with immediate assertions when Done is seen.
module tb_adder_acc;

  logic       Clk;
  logic       Reset_n;
  logic       Clear;
  logic       Start;
  logic [3:0] Count;
  logic       In_valid;
  logic [3:0] Sum;
  logic       Overflow;
  logic       Ack;
  logic [8:0] Total;
  logic [4:0] Ovf_cnt;
  logic       Busy;
  logic       Done;

  typedef struct {
    logic [8:0] t;
    logic [4:0] o;
  } res_t;

  res_t       exp_q[$];
  logic [8:0] m_total;
  logic [4:0] m_ovf;
  int         compared;
  int         mismatched;

  adder_acc dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Clear    (Clear),
    .Start    (Start),
    .Count    (Count),
    .In_valid (In_valid),
    .Sum      (Sum),
    .Overflow (Overflow),
    .Ack      (Ack),
    .Total    (Total),
    .Ovf_cnt  (Ovf_cnt),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [8:0] obs,
                     input logic [8:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_start(input logic [3:0] n);
    Start = 1'b1;
    Count = n;
    step();
    Start   = 1'b0;
    m_total = '0;
    m_ovf   = '0;
  endtask

  task automatic send(input logic ov, input logic [3:0] s);
    In_valid = 1'b1;
    Overflow = ov;
    Sum      = s;
    m_total  = m_total + {4'b0000, ov, s};
    m_ovf    = m_ovf + {4'b0000, ov};
    step();
    In_valid = 1'b0;
  endtask

  task automatic push_exp();
    res_t r;
    r.t = m_total;
    r.o = m_ovf;
    exp_q.push_back(r);
  endtask

  task automatic pop_cmp(input string tag);
    res_t r;
    chk({tag, "_qnonempty"}, 9'(exp_q.size() > 0), 9'd1);
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk({tag, "_total"}, Total, r.t);
      chk({tag, "_ovf"}, {4'b0000, Ovf_cnt}, {4'b0000, r.o});
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 40 && !Done; i++) step();
    chk({tag, "_done"}, {8'd0, Done}, 9'd1);
    pop_cmp(tag);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    m_total    = '0;
    m_ovf      = '0;
    Reset_n    = 1'b0;
    Clear      = 1'b0;
    Start      = 1'b0;
    Count      = 4'd0;
    In_valid   = 1'b0;
    Sum        = 4'd0;
    Overflow   = 1'b0;
    Ack        = 1'b0;
    #12;
    chk("rst_total", Total, 9'd0);
    chk("rst_ovf", {4'b0000, Ovf_cnt}, 9'd0);
    chk("rst_busy", {8'd0, Busy}, 9'd0);
    chk("rst_done", {8'd0, Done}, 9'd0);
    Reset_n = 1'b1;
    step();
    step();

    // three-sample run, Done one cycle after the last sample
    run_start(4'd3);
    chk("r1_busy", {8'd0, Busy}, 9'd1);
    send(1'b0, 4'd5);
    send(1'b1, 4'd2);
    chk("r1_notdone", {8'd0, Done}, 9'd0);
    send(1'b0, 4'd15);
    push_exp();
    chk("r1_done", {8'd0, Done}, 9'd1);
    chk("r1_busy_dn", {8'd0, Busy}, 9'd0);
    pop_cmp("r1");

    // held in DONE while In_valid toggles without Ack
    for (int i = 0; i < 5; i++) begin
      In_valid = i[0];
      Overflow = 1'b1;
      Sum      = 4'd9;
      step();
    end
    In_valid = 1'b0;
    chk("hold_total", Total, 9'd38);
    chk("hold_ovf", {4'b0000, Ovf_cnt}, 9'd1);
    chk("hold_done", {8'd0, Done}, 9'd1);
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    chk("ack_done", {8'd0, Done}, 9'd0);
    chk("ack_busy", {8'd0, Busy}, 9'd0);
    chk("ack_total", Total, 9'd38);

    // full sixteen-sample run with gaps
    run_start(4'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15)
        chk("r16_early", {8'd0, Done}, 9'd0);
      send(1'b1, 4'd15);
      if (i < 15) step();
    end
    push_exp();
    chk("r16_done", {8'd0, Done}, 9'd1);
    pop_cmp("r16");

    // Start together with Ack: only Ack counts
    Start = 1'b1;
    Ack   = 1'b1;
    Count = 4'd2;
    step();
    Ack = 1'b0;
    chk("sa_busy", {8'd0, Busy}, 9'd0);
    chk("sa_done", {8'd0, Done}, 9'd0);
    chk("sa_total", Total, 9'd496);
    step();
    Start   = 1'b0;
    m_total = '0;
    m_ovf   = '0;
    chk("sa_run", {8'd0, Busy}, 9'd1);
    chk("sa_clr", Total, 9'd0);
    send(1'b0, 4'd7);
    send(1'b1, 4'd1);
    push_exp();
    wait_done("r2");
    Ack = 1'b1;
    step();
    Ack = 1'b0;

    // Clear mid-run with a sample present
    run_start(4'd4);
    send(1'b0, 4'd3);
    send(1'b0, 4'd4);
    Clear    = 1'b1;
    In_valid = 1'b1;
    Sum      = 4'd8;
    step();
    Clear    = 1'b0;
    In_valid = 1'b0;
    chk("clr_busy", {8'd0, Busy}, 9'd0);
    chk("clr_total", Total, 9'd0);
    chk("clr_ovf", {4'b0000, Ovf_cnt}, 9'd0);
    send(1'b1, 4'd6);
    chk("clr_idle_ign", Total, 9'd0);

    // asynchronous reset mid-run
    run_start(4'd4);
    send(1'b1, 4'd1);
    send(1'b1, 4'd3);
    chk("pre_rst", Total, 9'd36);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_total", Total, 9'd0);
    chk("arst_ovf", {4'b0000, Ovf_cnt}, 9'd0);
    chk("arst_busy", {8'd0, Busy}, 9'd0);
    step();
    Reset_n = 1'b1;
    step();
    send(1'b1, 4'd2);
    chk("post_rst_ign", Total, 9'd0);
    chk("post_rst_busy", {8'd0, Busy}, 9'd0);

    run_start(4'd1);
    send(1'b1, 4'd0);
    push_exp();
    wait_done("r3");
    chk("q_empty", 9'(exp_q.size()), 9'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
